icache_refill_req_gen: RTL and testbench
========================================

// Module: icache_refill_req_gen
// PURPOSE
//  Miss-side counterpart of I-cache set-index extraction: takes a missed line's {tag, setid} and rebuilds its block address.
//  Queues up to DEPTH outstanding refills, merges duplicate misses to the same block and issues in-order memory read requests.
//  On each in-order memory response, returns {tag, setid, wid} so the I-cache can write the line and wake the warp.
//  Sits between the I-cache tag-compare stage and the L1/L2 memory request port.
// PARAMETERS
//  XLEN             32  system address width
//  SETIDXBITS        5  set index width (2^5 sets)
//  BLOCK_OFFSETBITS  1  byte-in-word offset bits
//  WORD_OFFSETBITS   1  word-in-block offset bits
//  WID_BITS          3  warp id width
//  DEPTH             4  outstanding refill entries; power of 2, >=2
//  TAGBITS  (localparam) XLEN-SETIDXBITS-BLOCK_OFFSETBITS-WORD_OFFSETBITS
// PORTS
//  clk              in   1         clock
//  rst              in   1         synchronous, active-high reset
//  miss_valid_i     in   1         miss request valid
//  miss_ready_o     out  1         miss request accepted when valid&ready
//  miss_tag_i       in   TAGBITS   missed line tag
//  miss_setid_i     in   SETIDXBITS missed line set index
//  miss_wid_i       in   WID_BITS  requesting warp
//  mem_req_valid_o  out  1         memory read request valid
//  mem_req_ready_i  in   1         memory accepts request
//  mem_req_addr_o   out  XLEN      block-aligned address
//  mem_rsp_valid_i  in   1         refill data returned (in issue order)
//  refill_valid_o   out  1         one-cycle pulse: oldest entry completed
//  refill_tag_o     out  TAGBITS   completed line tag
//  refill_setid_o   out  SETIDXBITS completed line set
//  refill_wid_o     out  WID_BITS  warp that allocated the entry
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset rst is synchronous and active-high.
//  Addr: mem_req_addr_o = {tag, setid, (BLOCK_OFFSETBITS+WORD_OFFSETBITS)'b0}.
//  Storage: circular buffer, DEPTH entries {valid, tag, setid, wid}; pointers alloc_ptr, issue_ptr, free_ptr, plus count.
//  Merge: miss matching {tag,setid} of any valid entry, excluding the entry freed this cycle -> accepted, no new entry, no new request.
//  miss_ready_o = (count<DEPTH) | merge_hit. Computed from current-cycle state only; no bypass of a same-cycle free.
//  Alloc: on accept without merge, write at alloc_ptr, alloc_ptr++ (wraps mod DEPTH), count++.
//  Issue: mem_req_valid_o = (issue_ptr != alloc_ptr) | issue_full_flag. Addr and fields come from entry[issue_ptr].
//    On valid&ready, issue_ptr++. valid/addr are combinational from registered state. Once valid is high it stays
//    high with a stable addr until ready.
//  Response: mem_rsp_valid_i with >=1 issued entry -> next cycle refill_valid_o=1 with entry[free_ptr] fields.
//    The entry invalidates, free_ptr++, count--.
//    mem_rsp_valid_i with no issued-unfreed entry -> ignored (SVA error in sim).
//  Simultaneous: alloc+free same cycle, count unchanged. Alloc, issue and free may all happen in one cycle.
//  Wrap: pointers are log2(DEPTH) bits. Full/empty and issued-all are resolved by count and an issued counter, not pointer equality.
//  Latency: miss accept -> mem_req_valid_o earliest next cycle. Response -> refill_valid_o exactly 1 cycle.
//  Reset values: miss_ready_o=1, mem_req_valid_o=0, refill_valid_o=0, refill_tag/setid/wid=0; all entries invalid, pointers and counters 0.
//  Reset mid-operation: all pending state is dropped. The memory side must be reset together with this block.
//  No merged-wid list: merged warps rely on I-cache replay after refill.
// STRUCTURE
//  icache_pkg: TAGBITS/offset localparams, refill_entry_t struct, function make_block_addr(tag,setid).
//  Single module; entry array and pointer logic inline; no sub-module required.
// TESTING (defaults: tag=[31:7], setid=[6:2], offset=[1:0])
//  1 Single miss tag=0x1,setid=3,wid=2, mem ready -> mem_req_addr_o=0x0000_008C next cycle;
//    rsp -> refill_valid_o pulse, tag=0x1, setid=3, wid=2.
//  2 Duplicate: same tag/setid twice from wid 2 and 5 -> both accepted, exactly one mem request, one refill (wid=2).
//  3 Fill: 4 distinct misses with mem_req_ready_i=0 -> 5th distinct miss sees miss_ready_o=0.
//    A 5th miss matching entry 0 is still accepted (merge).
//  4 Full + response + new miss same cycle -> miss_ready_o stays 0 that cycle; accepted next cycle, count returns to 4.
//  5 Wrap: stream 10 misses, addr=0x80*i, random ready/rsp -> requests and refills strictly in order, no loss, count never >4.
//  6 Reset with 3 pending -> next cycle mem_req_valid_o=0, miss_ready_o=1; a stray rsp is ignored (refill_valid_o stays 0).

Source files
------------

// File: rtl/icache_pkg.sv
// Shared I-cache refill types: address split widths, refill queue entry, block address builder.
package icache_pkg;

  localparam int XLEN             = 32;
  localparam int SETIDXBITS       = 5;
  localparam int BLOCK_OFFSETBITS = 1;
  localparam int WORD_OFFSETBITS  = 1;
  localparam int WID_BITS         = 3;
  localparam int OFFSETBITS       = BLOCK_OFFSETBITS + WORD_OFFSETBITS;
  localparam int TAGBITS          = XLEN - SETIDXBITS - OFFSETBITS;

  typedef struct packed {
    logic                  valid;
    logic [TAGBITS-1:0]    tag;
    logic [SETIDXBITS-1:0] setid;
    logic [WID_BITS-1:0]   wid;
  } refill_entry_t;

  function automatic logic [XLEN-1:0] make_block_addr(input logic [TAGBITS-1:0]    tag,
                                                      input logic [SETIDXBITS-1:0] setid);
    return {tag, setid, {OFFSETBITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_req_gen.sv
// Miss queue that merges duplicate misses and issues in-order block reads; request valid is next cycle after accept,
// refill pulse exactly one cycle after a response. Misses stall only when full and not merging with a live entry.
module icache_refill_req_gen
  import icache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [TAGBITS-1:0]    miss_tag_i,
  input  logic [SETIDXBITS-1:0] miss_setid_i,
  input  logic [WID_BITS-1:0]   miss_wid_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [XLEN-1:0]       mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  output logic                  refill_valid_o,
  output logic [TAGBITS-1:0]    refill_tag_o,
  output logic [SETIDXBITS-1:0] refill_setid_o,
  output logic [WID_BITS-1:0]   refill_wid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  refill_entry_t entries [DEPTH];
  logic [PW-1:0] alloc_ptr, issue_ptr, free_ptr;
  // count = allocated-not-freed, issued = issued-not-freed; pointer equality alone cannot tell full from empty
  logic [CW-1:0] count, issued;
  logic          merge_hit, alloc_fire, issue_fire, free_fire;

  assign free_fire = mem_rsp_valid_i & (issued != '0);

  // The slot being freed this cycle must not absorb a new miss: its refill pulse is already on its way.
  always_comb begin
    merge_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && entries[i].tag == miss_tag_i && entries[i].setid == miss_setid_i &&
          !(free_fire && free_ptr == PW'(i)))
        merge_hit = 1'b1;
    end
  end

  assign miss_ready_o    = (count < CW'(DEPTH)) | merge_hit;
  assign alloc_fire      = miss_valid_i & miss_ready_o & ~merge_hit;
  assign mem_req_valid_o = (count - issued) != '0;
  assign issue_fire      = mem_req_valid_o & mem_req_ready_i;
  assign mem_req_addr_o  = make_block_addr(entries[issue_ptr].tag, entries[issue_ptr].setid);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      alloc_ptr      <= '0;
      issue_ptr      <= '0;
      free_ptr       <= '0;
      count          <= '0;
      issued         <= '0;
      refill_valid_o <= 1'b0;
      refill_tag_o   <= '0;
      refill_setid_o <= '0;
      refill_wid_o   <= '0;
    end else begin
      if (alloc_fire) begin
        entries[alloc_ptr] <= '{valid: 1'b1, tag: miss_tag_i, setid: miss_setid_i, wid: miss_wid_i};
        alloc_ptr          <= alloc_ptr + PW'(1);
      end
      if (issue_fire) issue_ptr <= issue_ptr + PW'(1);
      if (free_fire) begin
        entries[free_ptr].valid <= 1'b0;
        free_ptr                <= free_ptr + PW'(1);
        refill_tag_o            <= entries[free_ptr].tag;
        refill_setid_o          <= entries[free_ptr].setid;
        refill_wid_o            <= entries[free_ptr].wid;
      end
      refill_valid_o <= free_fire;
      count          <= count + CW'(alloc_fire) - CW'(free_fire);
      issued         <= issued + CW'(issue_fire) - CW'(free_fire);
    end
  end

  // A response with nothing outstanding means the memory side lost sync with this queue.
  a_rsp_has_issued: assert property (@(posedge clk) disable iff (rst) !(mem_rsp_valid_i && issued == '0));

endmodule

// File: tb/tb_icache_refill_req_gen.sv
// Scoreboard bench: expected requests/refills queued on miss accept, popped as the DUT issues and completes.
module tb_icache_refill_req_gen;
  import icache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  miss_valid_i, miss_ready_o;
  logic [TAGBITS-1:0]    miss_tag_i;
  logic [SETIDXBITS-1:0] miss_setid_i;
  logic [WID_BITS-1:0]   miss_wid_i;
  logic                  mem_req_valid_o, mem_req_ready_i;
  logic [XLEN-1:0]       mem_req_addr_o;
  logic                  mem_rsp_valid_i;
  logic                  refill_valid_o;
  logic [TAGBITS-1:0]    refill_tag_o;
  logic [SETIDXBITS-1:0] refill_setid_o;
  logic [WID_BITS-1:0]   refill_wid_o;

  always #5 clk = ~clk;

  icache_refill_req_gen #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_tag_i(miss_tag_i), .miss_setid_i(miss_setid_i), .miss_wid_i(miss_wid_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .refill_valid_o(refill_valid_o), .refill_tag_o(refill_tag_o),
    .refill_setid_o(refill_setid_o), .refill_wid_o(refill_wid_o)
  );

  typedef struct packed {
    logic [TAGBITS-1:0]    tag;
    logic [SETIDXBITS-1:0] setid;
    logic [WID_BITS-1:0]   wid;
  } ent_t;

  typedef struct {
    logic [TAGBITS-1:0]    tag;
    logic [SETIDXBITS-1:0] setid;
    logic [WID_BITS-1:0]   wid;
    logic [31:0]           exp_addr;
  } vec_t;

  ent_t        live_q[$];
  ent_t        due_q[$];
  logic [31:0] req_q[$];
  int          nissued;
  int          checks, failures;
  int          dut_req, dut_ref;
  logic        miss_acc;
  logic        rand_mode;
  logic [31:0] miss_exp_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out", nm);
  endtask

  // One cycle: compare at negedge against the model, advance the model, then let the edge happen.
  task automatic step();
    int   pre_cnt, pre_iss;
    logic exp_rv, hit, exp_rdy;
    ent_t e;
    @(negedge clk);
    miss_acc = 1'b0;
    if (rst) begin
      live_q.delete(); due_q.delete(); req_q.delete();
      nissued = 0;
    end else begin
      if (mem_req_valid_o && mem_req_ready_i) dut_req++;
      if (refill_valid_o) dut_ref++;
      if (due_q.size() > 0) begin
        e = due_q.pop_front();
        chk("refill_valid", 32'(refill_valid_o), 32'd1);
        chk("refill_tag",   32'(refill_tag_o),   32'(e.tag));
        chk("refill_setid", 32'(refill_setid_o), 32'(e.setid));
        chk("refill_wid",   32'(refill_wid_o),   32'(e.wid));
      end else begin
        chk("refill_idle", 32'(refill_valid_o), 32'd0);
      end
      pre_cnt = live_q.size();
      pre_iss = nissued;
      exp_rv  = (pre_cnt - pre_iss) != 0;
      chk("mem_req_valid", 32'(mem_req_valid_o), 32'(exp_rv));
      if (exp_rv && req_q.size() > 0) chk("mem_req_addr", mem_req_addr_o, req_q[0]);
      if (exp_rv && mem_req_ready_i) begin
        void'(req_q.pop_front());
        nissued++;
      end
      if (mem_rsp_valid_i && pre_iss > 0) begin
        due_q.push_back(live_q.pop_front());
        nissued--;
      end
      if (miss_valid_i) begin
        hit = 1'b0;
        foreach (live_q[k])
          if (live_q[k].tag == miss_tag_i && live_q[k].setid == miss_setid_i) hit = 1'b1;
        exp_rdy = (pre_cnt < 4) || hit;
        chk("miss_ready", 32'(miss_ready_o), 32'(exp_rdy));
        if (exp_rdy) begin
          miss_acc = 1'b1;
          if (!hit) begin
            live_q.push_back('{tag: miss_tag_i, setid: miss_setid_i, wid: miss_wid_i});
            req_q.push_back(miss_exp_addr);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_mode) begin
      mem_req_ready_i = 1'($urandom_range(0, 1));
      mem_rsp_valid_i = (nissued > 0) && ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic do_miss(input logic [TAGBITS-1:0] t, input logic [SETIDXBITS-1:0] s,
                         input logic [WID_BITS-1:0] w, input logic [31:0] a);
    miss_valid_i  = 1'b1;
    miss_tag_i    = t;
    miss_setid_i  = s;
    miss_wid_i    = w;
    miss_exp_addr = a;
    for (int i = 0; i < 60; i++) begin
      step();
      if (miss_acc) break;
    end
    if (!miss_acc) timeout("miss_accept");
    miss_valid_i = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      mem_rsp_valid_i = nissued > 0;
      step();
      if (live_q.size() == 0 && due_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    mem_rsp_valid_i = 1'b0;
    if (!done) timeout("drain");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   r0, f0;
    vecs[0] = '{tag: 25'h1,       setid: 5'd3,  wid: 3'd2, exp_addr: 32'h0000_008C};
    vecs[1] = '{tag: 25'h1ABCDE,  setid: 5'd31, wid: 3'd7, exp_addr: 32'h0D5E_6F7C};
    vecs[2] = '{tag: 25'h0,       setid: 5'd0,  wid: 3'd0, exp_addr: 32'h0000_0000};
    vecs[3] = '{tag: 25'h1FFFFFF, setid: 5'd31, wid: 3'd1, exp_addr: 32'hFFFF_FFFC};

    checks = 0; failures = 0; dut_req = 0; dut_ref = 0; nissued = 0;
    rand_mode = 1'b0; rst = 1'b1;
    miss_valid_i = 1'b0; miss_tag_i = '0; miss_setid_i = '0; miss_wid_i = '0; miss_exp_addr = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    step(); step();
    chk("rst_miss_ready",   32'(miss_ready_o),    32'd1);
    chk("rst_mem_req_vld",  32'(mem_req_valid_o), 32'd0);
    chk("rst_refill_valid", 32'(refill_valid_o),  32'd0);
    chk("rst_refill_tag",   32'(refill_tag_o),    32'd0);
    chk("rst_refill_setid", 32'(refill_setid_o),  32'd0);
    chk("rst_refill_wid",   32'(refill_wid_o),    32'd0);
    rst = 1'b0;
    step();

    // single misses across the address range
    for (int v = 0; v < 4; v++) begin
      mem_req_ready_i = 1'b1;
      do_miss(vecs[v].tag, vecs[v].setid, vecs[v].wid, vecs[v].exp_addr);
      drain();
    end

    // duplicate miss merges into one request and one refill
    mem_req_ready_i = 1'b0;
    r0 = dut_req; f0 = dut_ref;
    do_miss(25'h40, 5'd1, 3'd2, 32'h0000_2004);
    do_miss(25'h40, 5'd1, 3'd5, 32'h0000_2004);
    drain();
    chk("dup_req_count",    32'(dut_req - r0), 32'd1);
    chk("dup_refill_count", 32'(dut_ref - f0), 32'd1);

    // fill with memory stalled; fifth distinct miss is refused, matching one merges
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      do_miss(25'(32'h100 + i), 5'(i), 3'(i), (32'h100 + 32'(i)) << 7 | 32'(i) << 2);
    miss_valid_i = 1'b1; miss_tag_i = 25'h1F0; miss_setid_i = 5'd9; miss_wid_i = 3'd3;
    miss_exp_addr = 32'h1F0 << 7 | 32'd9 << 2;
    step();
    chk("full_refuses", 32'(miss_acc), 32'd0);
    miss_valid_i = 1'b0;
    do_miss(25'h100, 5'd0, 3'd6, 32'h0000_8000);

    // full + response + new miss in the same cycle: no bypass of the free
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    miss_valid_i = 1'b1; miss_tag_i = 25'h200; miss_setid_i = 5'd2; miss_wid_i = 3'd1;
    miss_exp_addr = 32'h200 << 7 | 32'd2 << 2;
    step();
    chk("free_same_cycle_refused", 32'(miss_acc), 32'd0);
    mem_rsp_valid_i = 1'b0;
    step();
    chk("accept_after_free", 32'(miss_acc), 32'd1);
    miss_tag_i = 25'h201; miss_exp_addr = 32'h201 << 7 | 32'd2 << 2;
    step();
    chk("full_again", 32'(miss_acc), 32'd0);
    miss_valid_i = 1'b0;
    drain();

    // streaming with random backpressure and responses through pointer wrap
    rand_mode = 1'b1;
    r0 = dut_req; f0 = dut_ref;
    for (int i = 0; i < 10; i++) do_miss(25'(i), 5'd0, 3'(i % 8), 32'h80 * 32'(i));
    rand_mode = 1'b0;
    drain();
    chk("stream_req_count",    32'(dut_req - r0), 32'd10);
    chk("stream_refill_count", 32'(dut_ref - f0), 32'd10);

    // reset drops pending work; a response during reset is ignored
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) do_miss(25'(32'h300 + i), 5'd4, 3'(i), (32'h300 + 32'(i)) << 7 | 32'd4 << 2);
    rst = 1'b1;
    mem_rsp_valid_i = 1'b1;
    step();
    rst = 1'b0;
    mem_rsp_valid_i = 1'b0;
    chk("post_rst_mem_req_vld", 32'(mem_req_valid_o), 32'd0);
    chk("post_rst_miss_ready",  32'(miss_ready_o),    32'd1);
    chk("post_rst_refill",      32'(refill_valid_o),  32'd0);
    for (int i = 0; i < 3; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
